// File: rtl/test_ascii_generate.sv
// Synthetic ASCII text source: after execute it emits printable characters with a
// newline every LINE_LEN characters, one per CLK_DIV clocks, and stops after MAX_COUNT.
module test_ascii_generate #(
   parameter int         MAX_COUNT  = 2400,
   parameter int         LINE_LEN   = 80,
   parameter int         CLK_DIV    = 4,
   parameter logic [7:0] FIRST_CHAR = 8'h20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        execute,
   output logic [7:0]  generated_ascii,
   output logic [11:0] generate_count,
   output logic        ascii_valid,
   output logic        done
);

   localparam int COL_W = $clog2(LINE_LEN + 1);
   localparam int DIV_W = $clog2(CLK_DIV + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  ascii_q, ascii_d;
   logic [11:0] count_q, count_d;
   logic        valid_q, valid_d;
   logic        done_q, done_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [7:0]  ptr_q, ptr_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ascii_q <= 8'h00;
         count_q <= 12'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         div_q   <= '0;
         col_q   <= '0;
         ptr_q   <= FIRST_CHAR;
      end else begin
         state_q <= state_d;
         ascii_q <= ascii_d;
         count_q <= count_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         div_q   <= div_d;
         col_q   <= col_d;
         ptr_q   <= ptr_d;
      end
   end

   // Dropping execute in RUN takes priority over a pending tick, so an abort never emits.
   always_comb begin
      state_d = state_q;
      ascii_d = ascii_q;
      count_d = count_q;
      valid_d = 1'b0;
      done_d  = done_q;
      div_d   = div_q;
      col_d   = col_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (execute) begin
               state_d = RUN;
               count_d = 12'd0;
               col_d   = '0;
               div_d   = '0;
               done_d  = 1'b0;
               ptr_d   = FIRST_CHAR;
            end
         end
         RUN: begin
            if (!execute) begin
               state_d = IDLE;
            end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
               div_d   = '0;
               valid_d = 1'b1;
               count_d = count_q + 12'd1;
               if (col_q == COL_W'(LINE_LEN)) begin
                  ascii_d = 8'h0A;
                  col_d   = '0;
               end else begin
                  ascii_d = ptr_q;
                  col_d   = col_q + COL_W'(1);
                  ptr_d   = (ptr_q == 8'h7E) ? FIRST_CHAR : ptr_q + 8'd1;
               end
               if (count_q == 12'(MAX_COUNT - 1)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         DONE: begin
            if (!execute) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign generated_ascii = ascii_q;
   assign generate_count  = count_q;
   assign ascii_valid     = valid_q;
   assign done            = done_q;

endmodule

// File: tb/tb_test_ascii_generate.sv
// Bench for test_ascii_generate: drives execute (scripted and random) and compares
// every cycle against a model that derives each character from its position in the stream.
module tb_test_ascii_generate;

   localparam int         MAX_COUNT  = 2400;
   localparam int         LINE_LEN   = 80;
   localparam int         CLK_DIV    = 4;
   localparam logic [7:0] FIRST_CHAR = 8'h20;

   logic        clk;
   logic        reset;
   logic        execute;
   logic [7:0]  generated_ascii;
   logic [11:0] generate_count;
   logic        ascii_valid;
   logic        done;

   int checkCount;
   int passCount;

   // Reference model: phase 0 idle, 1 running, 2 finished
   int         mPhase;
   int         mT;
   int         mCount;
   logic [7:0] mChar;
   logic       mValid;
   logic       mDone;

   test_ascii_generate #(
      .MAX_COUNT (MAX_COUNT),
      .LINE_LEN  (LINE_LEN),
      .CLK_DIV   (CLK_DIV),
      .FIRST_CHAR(FIRST_CHAR)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .execute        (execute),
      .generated_ascii(generated_ascii),
      .generate_count (generate_count),
      .ascii_valid    (ascii_valid),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // The n-th character of a run (1-based): every (LINE_LEN+1)-th is a newline,
   // the rest walk the printable range and wrap.
   function automatic logic [7:0] charFor(input int n);
      int pos;
      int printable;
      int span;
      span = 8'h7F - FIRST_CHAR;
      pos  = (n - 1) % (LINE_LEN + 1);
      if (pos == LINE_LEN) return 8'h0A;
      printable = ((n - 1) / (LINE_LEN + 1)) * LINE_LEN + pos;
      return 8'(int'(FIRST_CHAR) + printable % span);
   endfunction

   task automatic modelReset();
      mPhase = 0;
      mT     = 0;
      mCount = 0;
      mChar  = 8'h00;
      mValid = 1'b0;
      mDone  = 1'b0;
   endtask

   task automatic modelStep(input logic e);
      mValid = 1'b0;
      case (mPhase)
         0: if (e) begin
               mPhase = 1;
               mT     = 0;
               mCount = 0;
               mDone  = 1'b0;
            end
         1: if (!e) begin
               mPhase = 0;
            end else begin
               mT++;
               if (mT % CLK_DIV == 0) begin
                  mCount++;
                  mChar  = charFor(mCount);
                  mValid = 1'b1;
                  if (mCount == MAX_COUNT) begin
                     mDone  = 1'b1;
                     mPhase = 2;
                  end
               end
            end
         default: if (!e) mPhase = 0;
      endcase
   endtask

   task automatic compareAll();
      checkOutput("ascii_valid", 32'(ascii_valid), 32'(mValid));
      checkOutput("generate_count", 32'(generate_count), 32'(mCount));
      checkOutput("generated_ascii", 32'(generated_ascii), 32'(mChar));
      checkOutput("done", 32'(done), 32'(mDone));
      if (mValid) begin
         case (mCount)
            1:  checkOutput("first_char", 32'(generated_ascii), 32'h20);
            2:  checkOutput("second_char", 32'(generated_ascii), 32'h21);
            80: checkOutput("last_of_line", 32'(generated_ascii), 32'h6F);
            81: checkOutput("newline", 32'(generated_ascii), 32'h0A);
            82: checkOutput("after_newline", 32'(generated_ascii), 32'h70);
            96: checkOutput("last_printable", 32'(generated_ascii), 32'h7E);
            97: checkOutput("pointer_wrap", 32'(generated_ascii), 32'h20);
            default: ;
         endcase
      end
   endtask

   task automatic applyStimulus(input logic e);
      execute = e;
      @(posedge clk);
      modelStep(e);
      #1;
      compareAll();
   endtask

   task automatic runToCount(input int target, input int budget);
      int n;
      n = 0;
      while (!(mValid && mCount == target) && n < budget) begin
         applyStimulus(1'b1);
         n++;
      end
      if (n >= budget) checkOutput("run_to_count_timeout", 32'(mCount), 32'(target));
   endtask

   task automatic checkZeroOutputs(input string tag);
      checkOutput({tag, "_ascii"}, 32'(generated_ascii), 32'h0);
      checkOutput({tag, "_count"}, 32'(generate_count), 32'h0);
      checkOutput({tag, "_valid"}, 32'(ascii_valid), 32'h0);
      checkOutput({tag, "_done"}, 32'(done), 32'h0);
   endtask

   initial begin
      int n;
      int abortAt;
      checkCount = 0;
      passCount  = 0;
      modelReset();
      reset   = 1'b1;
      execute = 1'b0;

      repeat (10) @(posedge clk);
      #1;
      checkZeroOutputs("reset");
      reset = 1'b0;
      repeat (3) applyStimulus(1'b0);

      // Abort at count 100, then hold idle
      runToCount(100, 1000);
      repeat (5) applyStimulus(1'b0);
      checkOutput("abort_hold_count", 32'(generate_count), 32'd100);

      // Full run to completion, then frozen outputs
      n = 0;
      while (!mDone && n < 12000) begin
         applyStimulus(1'b1);
         n++;
      end
      checkOutput("done_reached", 32'(done), 32'd1);
      checkOutput("done_count", 32'(generate_count), 32'(MAX_COUNT));
      repeat (60) applyStimulus(1'b1);
      repeat (4) applyStimulus(1'b0);
      checkOutput("done_held_idle", 32'(done), 32'd1);

      // Random abort point, restart, random execute pattern
      abortAt = int'($urandom_range(20, 400));
      repeat (abortAt) applyStimulus(1'b1);
      repeat (int'($urandom_range(1, 8))) applyStimulus(1'b0);
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom % 16) != 0);
      end
      repeat (3) applyStimulus(1'b0);

      // Asynchronous reset in the middle of a run
      runToCount(int'($urandom_range(5, 150)), 1000);
      repeat (2) applyStimulus(1'b1);
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkZeroOutputs("async_reset");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) applyStimulus(1'b0);
      runToCount(3, 100);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
